wall_scroller: RTL and testbench
================================

// Module: wall_scroller
// PURPOSE
//  Consumer end of the wall-height stream. Requests random heights from the
//  LFSR height generator with a req/valid handshake. Spawns up to two walls at
//  the right screen edge and scrolls them left on frame ticks. Exports wall
//  positions to the VGA drawer, and flags bird/wall collision and wall-passed events.
// PARAMETERS
//  SCREEN_W  160  screen width in pixels; spawn x = SCREEN_W-1
//  SCREEN_H  120  screen height in pixels
//  WALL_W    8    wall thickness in pixels
//  GAP_H     24   vertical opening height; gap spans [h, h+GAP_H)
//  SPACING   80   min x distance between consecutive walls before next spawn
//  SPEED_DIV 2    frame_ticks per 1-pixel step (>=1)
//  BIRD_X    40   fixed bird column, compared against wall span
// PORTS
//  clock         in   1  system clock
//  resetn        in   1  asynchronous, active-low reset
//  enable        in   1  game running; low returns FSM to IDLE and clears walls
//  frame_tick    in   1  one-cycle pulse per video frame
//  height_in     in   8  candidate wall gap top from generator
//  height_valid  in   1  height_in valid this cycle
//  height_req    out  1  request for a new height; held until accepted
//  bird_y        in   7  bird top row
//  wall0_x/1_x   out  8  left column of slot 0/1
//  wall0_h/1_h   out  8  gap top of slot 0/1 (post-clamp)
//  wall_active   out  2  bit i = slot i on screen
//  collision     out  1  sticky hit flag
//  pass_pulse    out  1  one-cycle pulse when a wall retires at x=0
//  score         out  8  walls passed (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, tick divider=0, next_slot=0.
//  - FSM: IDLE -> FETCH on enable; FETCH -> RUN on accept; RUN -> FETCH when
//    spawn needed; RUN/FETCH -> HALT on collision; any state -> IDLE when enable=0.
//  - Handshake: height_req=1 only in FETCH. Accept = height_req & height_valid
//    in the same cycle. height_req drops the cycle after accept. The height is
//    latched into slot next_slot with x=SCREEN_W-1 and active=1. next_slot toggles.
//  - Clamp: stored h = min(height_in, SCREEN_H-GAP_H). Example: 100 -> 96.
//  - Scrolling: divider counts frame_ticks. On the SPEED_DIV-th tick, divider
//    clears and every active slot with x>0 decrements x by 1. This continues
//    in FETCH, so a late generator never stalls the scroll.
//  - Retire: an active slot at x=0 on a step clears active and fires
//    pass_pulse. Two retires in one step give a single pulse and score+2.
//  - Spawn condition (RUN): the slot at next_slot is inactive, and either the
//    other slot is inactive or its x <= SCREEN_W-1-SPACING.
//  - Collision is evaluated every cycle in RUN/FETCH for each active slot.
//    The slot is hit when x <= BIRD_X < x+WALL_W (compare in 9 bits, no wrap)
//    and (bird_y < h or bird_y >= h+GAP_H).
//  - On collision: collision=1 (sticky), FSM=HALT, walls frozen, height_req=0.
//    Cleared only by enable=0 or resetn.
//  - enable=0: next cycle walls cleared, collision=0, height_req=0. score is held.
//    It clears only on resetn.
//  - Mid-handshake: enable=0 while in FETCH abandons the request. A height_valid
//    in the same cycle is ignored.
//  - score saturates at 255.
// CONFIGURATION
//  WALL_SCROLLER_SCORE_EN defined: score counts pass_pulse walls as above.
//  Undefined: no score counter is built, and score is tied to 8'd0.
//  pass_pulse is still generated.
// TESTING
//  1 reset, enable=1, height_valid held 0 -> height_req=1 persists; no active wall
//  2 height_in=45 with valid in FETCH -> next cycle wall0_h=45, wall0_x=159,
//    wall_active=01, height_req=0
//  3 height_in=100 -> wall_h=96 (clamp)
//  4 SPEED_DIV=2, 6 frame_ticks -> wall0_x=156; at x=79 second FETCH issues, then
//    wall1 spawns at 159
//  5 bird_y=10, wall0_h=45, scroll until x=40 -> collision=1, FSM HALT, x frozen;
//    enable=0 -> collision=0, wall_active=00
//  6 bird_y=50, gap 45..68, wall passes to x=0 and steps -> pass_pulse once,
//    score=1 (macro on) / score=0 (macro off)

Source files
------------

// File: rtl/wall_scroller.sv
// wall_scroller
//    Consumer end of the wall-height stream. Fetches gap heights from the
//    height generator with a req/valid handshake and spawns up to two walls
//    at the right screen edge. Walls scroll left on frame ticks. Also flags
//    bird/wall collisions and walls passing the left edge.
//
// Ports
//    clock, resetn        clock and async active-low reset
//    enable               game running; low clears walls and returns to IDLE
//    frame_tick           one-cycle pulse per video frame
//    height_in/_valid     candidate gap top and its valid strobe
//    height_req           asserted while waiting for a height
//    bird_y               bird top row
//    wall0_x/_h, wall1_x/_h   left column and clamped gap top per slot
//    wall_active          bit i = slot i on screen
//    collision            sticky hit flag
//    pass_pulse           one-cycle pulse when wall(s) retire at x=0
//    score                walls passed, saturating at 255
//
// Build option
//    WALL_SCROLLER_SCORE_EN  defined: score counter built.
//                            undefined: score tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | game stopped, walls cleared
// S_FETCH | height_req high, walls keep scrolling
// S_RUN   | scrolling, checking whether a spawn is due
// S_HALT  | collision seen, walls frozen until enable=0
module wall_scroller #(
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int WALL_W    = 8,
   parameter int GAP_H     = 24,
   parameter int SPACING   = 80,
   parameter int SPEED_DIV = 2,
   parameter int BIRD_X    = 40
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic [7:0] height_in,
   input  logic       height_valid,
   output logic       height_req,
   input  logic [6:0] bird_y,
   output logic [7:0] wall0_x,
   output logic [7:0] wall1_x,
   output logic [7:0] wall0_h,
   output logic [7:0] wall1_h,
   output logic [1:0] wall_active,
   output logic       collision,
   output logic       pass_pulse,
   output logic [7:0] score
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_HALT} state_t;

   localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);
   localparam logic [7:0] SPAWN_X     = 8'(SCREEN_W - 1);
   localparam logic [7:0] SPAWN_LIMIT = 8'(SCREEN_W - 1 - SPACING);
   localparam logic [7:0] H_MAX       = 8'(SCREEN_H - GAP_H);
   localparam logic [8:0] BIRD_X9     = 9'(BIRD_X);
   localparam logic [8:0] WALL_W9     = 9'(WALL_W);
   localparam logic [8:0] GAP_H9      = 9'(GAP_H);

   state_t           state_q, state_d;
   logic [7:0]       x_q [2];
   logic [7:0]       h_q [2];
   logic [1:0]       active_q;
   logic             next_slot_q;
   logic [DIV_W-1:0] div_q;
   logic             collision_q;
   logic             pass_q;

   logic       scrolling, hit_any, tick_cnt, step, accept, spawn_need;
   logic [1:0] hit, retire;
   logic [8:0] bird_y9;
   logic [7:0] h_clamped;

   assign bird_y9    = {2'b00, bird_y};
   assign h_clamped  = (height_in > H_MAX) ? H_MAX : height_in;
   assign scrolling  = (state_q == S_FETCH) || (state_q == S_RUN);
   assign height_req = (state_q == S_FETCH);

   // All compares are 9 bits wide so x+WALL_W and h+GAP_H never wrap.
   always_comb begin
      hit = '0;
      for (int i = 0; i < 2; i++) begin
         hit[i] = active_q[i]
                  && ({1'b0, x_q[i]} <= BIRD_X9)
                  && (BIRD_X9 < ({1'b0, x_q[i]} + WALL_W9))
                  && ((bird_y9 < {1'b0, h_q[i]})
                      || (bird_y9 >= ({1'b0, h_q[i]} + GAP_H9)));
      end
   end

   // A hit freezes everything in the same cycle so the wall stops at the
   // position where the collision was seen.
   assign hit_any  = scrolling && (|hit);
   assign tick_cnt = enable && scrolling && frame_tick && !hit_any;
   assign step     = tick_cnt && (div_q == DIV_LAST);
   assign accept   = enable && height_req && height_valid && !hit_any;
   assign retire[0] = step && active_q[0] && (x_q[0] == 8'd0);
   assign retire[1] = step && active_q[1] && (x_q[1] == 8'd0);

   assign spawn_need = !active_q[next_slot_q]
                       && (!active_q[~next_slot_q]
                           || (x_q[~next_slot_q] <= SPAWN_LIMIT));

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (hit_any) state_d = S_HALT;
                     else if (accept) state_d = S_RUN;
            S_RUN:   if (hit_any) state_d = S_HALT;
                     else if (spawn_need) state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_q[0]      <= '0;
         x_q[1]      <= '0;
         h_q[0]      <= '0;
         h_q[1]      <= '0;
         active_q    <= '0;
         next_slot_q <= 1'b0;
         div_q       <= '0;
         collision_q <= 1'b0;
         pass_q      <= 1'b0;
      end else if (!enable) begin
         x_q[0]      <= '0;
         x_q[1]      <= '0;
         h_q[0]      <= '0;
         h_q[1]      <= '0;
         active_q    <= '0;
         next_slot_q <= 1'b0;
         div_q       <= '0;
         collision_q <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         pass_q <= |retire;
         if (hit_any) collision_q <= 1'b1;
         if (tick_cnt) div_q <= step ? '0 : div_q + 1'b1;
         if (step) begin
            for (int i = 0; i < 2; i++) begin
               if (retire[i])        active_q[i] <= 1'b0;
               else if (active_q[i]) x_q[i] <= x_q[i] - 8'd1;
            end
         end
         // The target slot is always inactive here, so this never races a step.
         if (accept) begin
            x_q[next_slot_q]      <= SPAWN_X;
            h_q[next_slot_q]      <= h_clamped;
            active_q[next_slot_q] <= 1'b1;
            next_slot_q           <= ~next_slot_q;
         end
      end
   end

`ifdef WALL_SCROLLER_SCORE_EN
   logic [7:0] score_q;
   logic [8:0] score_sum;

   assign score_sum = {1'b0, score_q} + {8'd0, retire[0]} + {8'd0, retire[1]};

   // Held across enable=0; only resetn clears the score.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) score_q <= '0;
      else         score_q <= score_sum[8] ? 8'hff : score_sum[7:0];
   end

   assign score = score_q;
`else
   assign score = 8'd0;
`endif

   assign wall0_x     = x_q[0];
   assign wall1_x     = x_q[1];
   assign wall0_h     = h_q[0];
   assign wall1_h     = h_q[1];
   assign wall_active = active_q;
   assign collision   = collision_q;
   assign pass_pulse  = pass_q;

endmodule

// File: tb/tb_wall_scroller.sv
module tb_wall_scroller;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] height_in = 8'd0;
   logic       height_valid = 1'b0;
   logic       height_req;
   logic [6:0] bird_y = 7'd50;
   logic [7:0] wall0_x, wall1_x, wall0_h, wall1_h;
   logic [1:0] wall_active;
   logic       collision, pass_pulse;
   logic [7:0] score;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;
   logic [7:0] sb_q [$];

`ifdef WALL_SCROLLER_SCORE_EN
   localparam logic [7:0] SCORE_AFTER_PASS = 8'd1;
`else
   localparam logic [7:0] SCORE_AFTER_PASS = 8'd0;
`endif

   wall_scroller dut (
      .clock(clock), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
      .height_in(height_in), .height_valid(height_valid), .height_req(height_req),
      .bird_y(bird_y), .wall0_x(wall0_x), .wall1_x(wall1_x), .wall0_h(wall0_h),
      .wall1_h(wall1_h), .wall_active(wall_active), .collision(collision),
      .pass_pulse(pass_pulse), .score(score)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (pass_pulse) pulse_cnt++;

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
      end
   endtask

   // One frame: tick high for one cycle, low for one cycle.
   task automatic frame();
      frame_tick = 1'b1;
      @(posedge clock); #1;
      frame_tick = 1'b0;
      @(posedge clock); #1;
   endtask

   // Waits for a request, drives one height, then pops the scoreboard when the
   // slot comes alive.
   task automatic spawn_wall(input logic [7:0] hin, input int slot, input string name);
      int n;
      logic [7:0] exp_h, got_h, got_x;
      n = 0;
      while (!height_req && n < 50) begin cycles(1); n++; end
      checks++;
      if (!height_req) begin
         failures++;
         $display("FAIL %s_req got=%b want=1 (timeout)", name, height_req);
         return;
      end
      exp_h = (hin > 8'd96) ? 8'd96 : hin;
      sb_q.push_back(exp_h);
      height_in = hin;
      height_valid = 1'b1;
      @(posedge clock); #1;
      height_valid = 1'b0;
      n = 0;
      while (!wall_active[slot] && n < 10) begin cycles(1); n++; end
      checks++;
      if (!wall_active[slot]) begin
         failures++;
         $display("FAIL %s_active got=%b want slot %0d set", name, wall_active, slot);
         return;
      end
      got_h = (slot == 0) ? wall0_h : wall1_h;
      got_x = (slot == 0) ? wall0_x : wall1_x;
      exp_h = sb_q.pop_front();
      checks++;
      if (got_h !== exp_h) begin
         failures++; $display("FAIL %s_h got=%0d want=%0d", name, got_h, exp_h);
      end
      checks++;
      if (got_x !== 8'd159) begin
         failures++; $display("FAIL %s_x got=%0d want=159", name, got_x);
      end
      checks++;
      if (height_req !== 1'b0) begin
         failures++; $display("FAIL %s_req_drop got=%b want=0", name, height_req);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cycles(3);
      checks++;
      if ({height_req, wall_active, collision, pass_pulse} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got req=%b act=%b col=%b pass=%b want all 0",
                  height_req, wall_active, collision, pass_pulse);
      end
      checks++;
      if ({wall0_x, wall1_x, wall0_h, wall1_h, score} !== 40'd0) begin
         failures++;
         $display("FAIL reset_data got x0=%0d x1=%0d h0=%0d h1=%0d score=%0d want 0",
                  wall0_x, wall1_x, wall0_h, wall1_h, score);
      end
      resetn = 1'b1;
      cycles(1);
   endtask

   task automatic test_fetch_hold();
      enable = 1'b1;
      cycles(6);
      checks++;
      if (height_req !== 1'b1) begin
         failures++; $display("FAIL hold_req got=%b want=1", height_req);
      end
      checks++;
      if (wall_active !== 2'b00) begin
         failures++; $display("FAIL hold_active got=%b want=00", wall_active);
      end
   endtask

   task automatic test_spawn();
      spawn_wall(8'd45, 0, "spawn0");
      checks++;
      if (wall_active !== 2'b01) begin
         failures++; $display("FAIL spawn0_mask got=%b want=01", wall_active);
      end
   endtask

   task automatic test_scroll_and_clamp();
      int n;
      for (int i = 0; i < 6; i++) frame();
      checks++;
      if (wall0_x !== 8'd156) begin
         failures++; $display("FAIL scroll6 got=%0d want=156", wall0_x);
      end
      n = 0;
      while (wall0_x != 8'd80 && n < 400) begin frame(); n++; end
      checks++;
      if (height_req !== 1'b0 || wall0_x !== 8'd80) begin
         failures++;
         $display("FAIL no_spawn_at80 got req=%b x=%0d want req=0 x=80", height_req, wall0_x);
      end
      n = 0;
      while (wall0_x != 8'd79 && n < 10) begin frame(); n++; end
      checks++;
      if (height_req !== 1'b1 || wall0_x !== 8'd79) begin
         failures++;
         $display("FAIL fetch_at79 got req=%b x=%0d want req=1 x=79", height_req, wall0_x);
      end
      spawn_wall(8'd100, 1, "clamp1");
      checks++;
      if (wall_active !== 2'b11 || wall0_x !== 8'd79) begin
         failures++;
         $display("FAIL two_walls got act=%b x0=%0d want act=11 x0=79", wall_active, wall0_x);
      end
   endtask

   task automatic test_collision();
      int n;
      logic [7:0] x1_frozen;
      bird_y = 7'd10;
      n = 0;
      while (!collision && n < 200) begin frame(); n++; end
      checks++;
      if (collision !== 1'b1 || wall0_x !== 8'd40) begin
         failures++;
         $display("FAIL hit got col=%b x0=%0d want col=1 x0=40", collision, wall0_x);
      end
      x1_frozen = wall1_x;
      for (int i = 0; i < 6; i++) frame();
      checks++;
      if (wall0_x !== 8'd40 || wall1_x !== x1_frozen || height_req !== 1'b0
          || collision !== 1'b1) begin
         failures++;
         $display("FAIL halt_freeze got x0=%0d x1=%0d req=%b col=%b want x0=40 x1=%0d req=0 col=1",
                  wall0_x, wall1_x, height_req, collision, x1_frozen);
      end
      enable = 1'b0;
      cycles(1);
      checks++;
      if (collision !== 1'b0 || wall_active !== 2'b00) begin
         failures++;
         $display("FAIL disable_clear got col=%b act=%b want col=0 act=00", collision, wall_active);
      end
   endtask

   task automatic test_pass();
      int n;
      bird_y = 7'd50;
      enable = 1'b1;
      cycles(1);
      spawn_wall(8'd45, 0, "pass0");
      pulse_cnt = 0;
      n = 0;
      // No height is offered while the second fetch is pending, so the wall
      // must keep scrolling through FETCH all the way to the left edge.
      while (wall_active[0] && n < 400) begin frame(); n++; end
      checks++;
      if (wall_active[0] !== 1'b0 || pulse_cnt != 1) begin
         failures++;
         $display("FAIL pass_pulse got act0=%b pulses=%0d want act0=0 pulses=1",
                  wall_active[0], pulse_cnt);
      end
      checks++;
      if (collision !== 1'b0 || height_req !== 1'b1) begin
         failures++;
         $display("FAIL pass_state got col=%b req=%b want col=0 req=1", collision, height_req);
      end
      checks++;
      if (score !== SCORE_AFTER_PASS) begin
         failures++; $display("FAIL score got=%0d want=%0d", score, SCORE_AFTER_PASS);
      end
   endtask

   task automatic test_abandon();
      enable = 1'b0;
      height_in = 8'd30;
      height_valid = 1'b1;
      cycles(1);
      height_valid = 1'b0;
      checks++;
      if (wall_active !== 2'b00 || height_req !== 1'b0) begin
         failures++;
         $display("FAIL abandon got act=%b req=%b want act=00 req=0", wall_active, height_req);
      end
      enable = 1'b1;
      cycles(3);
      checks++;
      if (wall_active !== 2'b00 || height_req !== 1'b1) begin
         failures++;
         $display("FAIL abandon_restart got act=%b req=%b want act=00 req=1",
                  wall_active, height_req);
      end
      checks++;
      if (score !== SCORE_AFTER_PASS) begin
         failures++; $display("FAIL score_held got=%0d want=%0d", score, SCORE_AFTER_PASS);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_hold();
      test_spawn();
      test_scroll_and_clamp();
      test_collision();
      test_pass();
      test_abandon();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
